// File: rtl/run_controller.sv
// run_controller
// ---------------------------------------------------------------------------
// Hardware run harness that sits directly upstream of the processor
// `toplevel`. One run has these steps:
//   1. Zero the whole 256-byte data memory.
//   2. Accept a stream of preload bytes into data memory.
//   3. Hold the processor in reset (START high) for START_CYCLES cycles.
//   4. Release START and wait for DONE, bounded by TIMEOUT_CYCLES.
//   5. Stream RES_COUNT bytes back out, starting at RES_BASE.
//
// Ports
//   CLK, RESET          single clock; synchronous active-high reset
//   GO                  run request, sampled only while idle
//   BUSY                high whenever a run is in progress
//   ERR_TIMEOUT         sticky abort flag, cleared when the next GO is taken
//   START               to toplevel.START (high = processor held in reset)
//   DONE                from toplevel.DONE
//   LD_WE/LD_ADDR/LD_DATA   data-memory write port (clear + preload)
//   RD_ADDR/RD_DATA     data-memory combinational read port (drain)
//   PL_VALID/PL_READY/PL_ADDR/PL_DATA/PL_LAST   preload stream in
//   RES_VALID/RES_READY/RES_DATA/RES_LAST       result stream out
//
// All outputs are decoded from registered state, so a reset forces every
// output back to its idle value on the very next cycle.
// ---------------------------------------------------------------------------
module run_controller #(
    parameter int START_CYCLES   = 2,
    parameter int RES_BASE       = 5,
    parameter int RES_COUNT      = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       GO,
    output logic       BUSY,
    output logic       ERR_TIMEOUT,
    output logic       START,
    input  logic       DONE,
    output logic       LD_WE,
    output logic [7:0] LD_ADDR,
    output logic [7:0] LD_DATA,
    output logic [7:0] RD_ADDR,
    input  logic [7:0] RD_DATA,
    input  logic       PL_VALID,
    output logic       PL_READY,
    input  logic [7:0] PL_ADDR,
    input  logic [7:0] PL_DATA,
    input  logic       PL_LAST,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [7:0] RES_DATA,
    output logic       RES_LAST
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAUNCH_END = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_END    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       CLEAR_END  = 9'd255;
    localparam logic [8:0]       IDX_LAST   = 9'(RES_COUNT - 1);
    localparam logic [7:0]       BASE_ADDR  = 8'(RES_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PRELOAD,
        S_LAUNCH,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       idx_q, idx_d;     // clear address / result beat index
    logic [CNT_W-1:0] cnt_q, cnt_d;     // launch hold / run watchdog
    logic             err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        BUSY        = (state_q != S_IDLE);
        ERR_TIMEOUT = err_q;
        START       = 1'b1;
        LD_WE       = 1'b0;
        LD_ADDR     = 8'd0;
        LD_DATA     = 8'd0;
        RD_ADDR     = 8'd0;
        PL_READY    = 1'b0;
        RES_VALID   = 1'b0;
        RES_DATA    = 8'd0;
        RES_LAST    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (GO) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end

            S_CLEAR: begin
                LD_WE   = 1'b1;
                LD_ADDR = idx_q[7:0];
                if (idx_q == CLEAR_END) begin
                    state_d = S_PRELOAD;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end

            S_PRELOAD: begin
                // The write port follows the stream directly, so an accepted
                // beat lands in memory in the same cycle it is offered.
                PL_READY = 1'b1;
                LD_WE    = PL_VALID;
                LD_ADDR  = PL_VALID ? PL_ADDR : 8'd0;
                LD_DATA  = PL_VALID ? PL_DATA : 8'd0;
                if (PL_VALID && PL_LAST) begin
                    state_d = S_LAUNCH;
                    cnt_d   = '0;
                end
            end

            S_LAUNCH: begin
                // DONE is meaningless here: the processor is still in reset.
                if (cnt_q == LAUNCH_END) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RUN: begin
                START = 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                // DONE takes priority over a watchdog expiry in the same cycle.
                if (DONE) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else if (cnt_q == RUN_END) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end

            S_DRAIN: begin
                START     = 1'b0;
                // 8-bit add wraps the read window past address 255.
                RD_ADDR   = BASE_ADDR + idx_q[7:0];
                RES_VALID = 1'b1;
                RES_DATA  = RD_DATA;
                RES_LAST  = (idx_q == IDX_LAST);
                if (RES_READY) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
// Directed bench for run_controller. Two instances share all stimulus:
// dut_a uses RES_BASE=5, dut_b uses RES_BASE=254 to exercise the read
// address wrap. Both use TIMEOUT_CYCLES=50. Each instance has a 256-byte
// memory model, and a processor stub can write result bytes into it.
module tb_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, go, done, pl_valid, pl_last, res_ready;
    logic [7:0] pl_addr, pl_data;

    logic       busy_a, err_a, start_a, ld_we_a, pl_ready_a, res_valid_a, res_last_a;
    logic [7:0] ld_addr_a, ld_data_a, rd_addr_a, rd_data_a, res_data_a;
    logic       busy_b, err_b, start_b, ld_we_b, pl_ready_b, res_valid_b, res_last_b;
    logic [7:0] ld_addr_b, ld_data_b, rd_addr_b, rd_data_b, res_data_b;

    logic       proc_we;
    logic [7:0] proc_addr, proc_data;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int checks = 0;
    int errors = 0;

    run_controller #(
        .START_CYCLES(2), .RES_BASE(5), .RES_COUNT(4), .TIMEOUT_CYCLES(50)
    ) dut_a (
        .CLK(clk), .RESET(rst), .GO(go), .BUSY(busy_a), .ERR_TIMEOUT(err_a),
        .START(start_a), .DONE(done),
        .LD_WE(ld_we_a), .LD_ADDR(ld_addr_a), .LD_DATA(ld_data_a),
        .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a),
        .PL_VALID(pl_valid), .PL_READY(pl_ready_a), .PL_ADDR(pl_addr),
        .PL_DATA(pl_data), .PL_LAST(pl_last),
        .RES_VALID(res_valid_a), .RES_READY(res_ready), .RES_DATA(res_data_a),
        .RES_LAST(res_last_a)
    );

    run_controller #(
        .START_CYCLES(2), .RES_BASE(254), .RES_COUNT(4), .TIMEOUT_CYCLES(50)
    ) dut_b (
        .CLK(clk), .RESET(rst), .GO(go), .BUSY(busy_b), .ERR_TIMEOUT(err_b),
        .START(start_b), .DONE(done),
        .LD_WE(ld_we_b), .LD_ADDR(ld_addr_b), .LD_DATA(ld_data_b),
        .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b),
        .PL_VALID(pl_valid), .PL_READY(pl_ready_b), .PL_ADDR(pl_addr),
        .PL_DATA(pl_data), .PL_LAST(pl_last),
        .RES_VALID(res_valid_b), .RES_READY(res_ready), .RES_DATA(res_data_b),
        .RES_LAST(res_last_b)
    );

    always @(posedge clk) begin
        if (ld_we_a) mem_a[ld_addr_a] <= ld_data_a;
        else if (proc_we) mem_a[proc_addr] <= proc_data;
    end

    always @(posedge clk) begin
        if (ld_we_b) mem_b[ld_addr_b] <= ld_data_b;
        else if (proc_we) mem_b[proc_addr] <= proc_data;
    end

    assign rd_data_a = mem_a[rd_addr_a];
    assign rd_data_b = mem_b[rd_addr_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one preload cycle and check the write port it produces.
    task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic l, input logic v);
        pl_valid = v;
        pl_addr  = a;
        pl_data  = d;
        pl_last  = l;
        #1;
        chk("pl_we", 32'(ld_we_a), 32'(v));
        chk("pl_addr", 32'(ld_addr_a), v ? 32'(a) : 32'd0);
        chk("pl_data", 32'(ld_data_a), v ? 32'(d) : 32'd0);
        cyc();
    endtask

    // GO, full clear, one-beat preload, launch; returns in the first RUN cycle.
    task automatic launch_run();
        go = 1'b1;
        cyc();
        go = 1'b0;
        repeat (256) cyc();
        chk("run_pl_ready", 32'(pl_ready_a), 32'd1);
        pl_valid = 1'b1;
        pl_addr  = 8'd9;
        pl_data  = 8'd7;
        pl_last  = 1'b1;
        cyc();
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        cyc();
        cyc();
        chk("run_entry_start", 32'(start_a), 32'd0);
    endtask

    int rdy   [7] = '{1, 0, 0, 1, 0, 1, 1};
    int e_adr [7] = '{5, 6, 6, 6, 7, 7, 8};
    int e_dat [7] = '{1, 2, 2, 2, 3, 3, 4};
    int e_lst [7] = '{0, 0, 0, 0, 0, 0, 1};
    int e_adb [7] = '{254, 255, 255, 255, 0, 0, 1};

    initial begin
        rst = 1'b1; go = 1'b0; done = 1'b0; res_ready = 1'b0;
        pl_valid = 1'b0; pl_last = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
        proc_we = 1'b0; proc_addr = 8'd0; proc_data = 8'd0;
        cyc();
        cyc();

        // Reset state
        chk("rst_start", 32'(start_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_ld_we", 32'(ld_we_a), 32'd0);
        chk("rst_pl_ready", 32'(pl_ready_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid_a), 32'd0);
        chk("rst_res_last", 32'(res_last_a), 32'd0);
        chk("rst_ld_addr", 32'(ld_addr_a), 32'd0);
        chk("rst_ld_data", 32'(ld_data_a), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr_a), 32'd0);
        chk("rst_res_data", 32'(res_data_a), 32'd0);

        // Run 1: full run, GO held high throughout, backpressured drain
        rst = 1'b0;
        go  = 1'b1;
        cyc();
        chk("clr_busy", 32'(busy_a), 32'd1);
        chk("clr_start", 32'(start_a), 32'd1);
        chk("clr_pl_ready", 32'(pl_ready_a), 32'd0);
        for (int k = 0; k < 256; k++) begin
            chk("clr_we", 32'(ld_we_a), 32'd1);
            chk("clr_addr", 32'(ld_addr_a), 32'(k));
            chk("clr_data", 32'(ld_data_a), 32'd0);
            cyc();
        end
        chk("pre_ready", 32'(pl_ready_a), 32'd1);
        chk("pre_idle_we", 32'(ld_we_a), 32'd0);
        chk("pre_start", 32'(start_a), 32'd1);
        chk("clr_mem200", 32'(mem_a[200]), 32'd0);
        chk("clr_mem255", 32'(mem_a[255]), 32'd0);

        beat(8'd0, 8'd85, 1'b0, 1'b1);
        beat(8'd1, 8'd9,  1'b0, 1'b1);
        beat(8'd0, 8'd0,  1'b1, 1'b0);   // PL_LAST without PL_VALID
        beat(8'd1, 8'd5,  1'b0, 1'b1);   // overwrite of address 1
        beat(8'd2, 8'd85, 1'b0, 1'b1);
        beat(8'd3, 8'd5,  1'b1, 1'b1);
        pl_valid = 1'b0;
        pl_last  = 1'b0;

        // p+1: LAUNCH, DONE pulsed while processor is held
        chk("launch1_start", 32'(start_a), 32'd1);
        chk("launch1_ready", 32'(pl_ready_a), 32'd0);
        chk("launch1_busy", 32'(busy_a), 32'd1);
        chk("mem0", 32'(mem_a[0]), 32'd85);
        chk("mem1_overwrite", 32'(mem_a[1]), 32'd5);
        chk("mem2", 32'(mem_a[2]), 32'd85);
        chk("mem3", 32'(mem_a[3]), 32'd5);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("launch2_start", 32'(start_a), 32'd1);
        cyc();

        // RUN: stub writes results, DONE 20 cycles after START fell
        for (int i = 0; i < 20; i++) begin
            proc_we   = (i < 4);
            proc_addr = 8'(5 + i);
            proc_data = 8'(1 + i);
            chk("run_start", 32'(start_a), 32'd0);
            chk("run_res_valid", 32'(res_valid_a), 32'd0);
            cyc();
        end
        proc_we = 1'b0;
        chk("run_before_done", 32'(res_valid_a), 32'd0);
        done = 1'b1;
        cyc();
        done = 1'b0;

        for (int i = 0; i < 7; i++) begin
            res_ready = rdy[i][0];
            if (i == 6) go = 1'b0;
            #1;
            chk("drn_valid", 32'(res_valid_a), 32'd1);
            chk("drn_rd_addr", 32'(rd_addr_a), 32'(e_adr[i]));
            chk("drn_data", 32'(res_data_a), 32'(e_dat[i]));
            chk("drn_last", 32'(res_last_a), 32'(e_lst[i]));
            chk("drn_start", 32'(start_a), 32'd0);
            chk("wrap_rd_addr", 32'(rd_addr_b), 32'(e_adb[i]));
            cyc();
        end
        res_ready = 1'b0;
        chk("end_busy", 32'(busy_a), 32'd0);
        chk("end_valid", 32'(res_valid_a), 32'd0);
        chk("end_start", 32'(start_a), 32'd1);
        chk("end_last", 32'(res_last_a), 32'd0);
        cyc();
        chk("no_restart", 32'(busy_a), 32'd0);

        // Run 2: DONE never arrives; abort exactly 50 cycles after START fell
        launch_run();
        repeat (49) cyc();
        chk("to_pre_busy", 32'(busy_a), 32'd1);
        chk("to_pre_err", 32'(err_a), 32'd0);
        chk("to_pre_start", 32'(start_a), 32'd0);
        cyc();
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_busy", 32'(busy_a), 32'd0);
        chk("to_start", 32'(start_a), 32'd1);
        cyc();
        chk("to_sticky", 32'(err_a), 32'd1);
        go = 1'b1;
        cyc();
        go = 1'b0;
        chk("go_clears_err", 32'(err_a), 32'd0);
        chk("go_busy", 32'(busy_a), 32'd1);
        chk("go_ld_addr", 32'(ld_addr_a), 32'd0);

        // Run 3: reset while clearing address 100
        repeat (100) cyc();
        chk("mid_ld_addr", 32'(ld_addr_a), 32'd100);
        chk("mid_ld_we", 32'(ld_we_a), 32'd1);
        rst = 1'b1;
        cyc();
        chk("mrst_ld_we", 32'(ld_we_a), 32'd0);
        chk("mrst_start", 32'(start_a), 32'd1);
        chk("mrst_busy", 32'(busy_a), 32'd0);
        chk("mrst_ld_addr", 32'(ld_addr_a), 32'd0);
        chk("mrst_pl_ready", 32'(pl_ready_a), 32'd0);
        rst = 1'b0;
        cyc();
        chk("mrst_idle", 32'(busy_a), 32'd0);

        // Run 4: DONE in the same cycle as the watchdog limit; DONE wins
        launch_run();
        for (int i = 0; i < 49; i++) begin
            proc_we   = (i < 4);
            proc_addr = 8'(5 + i);
            proc_data = 8'(16 * (i + 1));
            cyc();
        end
        proc_we = 1'b0;
        chk("tie_busy", 32'(busy_a), 32'd1);
        chk("tie_err", 32'(err_a), 32'd0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_valid", 32'(res_valid_a), 32'd1);
            chk("tie_rd_addr", 32'(rd_addr_a), 32'(5 + i));
            chk("tie_data", 32'(res_data_a), 32'(16 * (i + 1)));
            chk("tie_last", 32'(res_last_a), (i == 3) ? 32'd1 : 32'd0);
            chk("tie_no_err", 32'(err_a), 32'd0);
            cyc();
        end
        res_ready = 1'b0;
        chk("tie_end_busy", 32'(busy_a), 32'd0);
        chk("tie_end_err", 32'(err_a), 32'd0);
        chk("tie_end_start", 32'(start_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run harness that sits directly upstream of `toplevel`. It initialises the processor's data memory, then drives the `START` launch pulse. It waits for `DONE` and streams the result bytes back out of data memory. It replaces the simulation-only init/launch/readout sequence so a program run can execute on hardware.

## Interface
Parameters:
- `START_CYCLES`, 2: cycles `START` stays high after preload, before launch (≥1).
- `RES_BASE`, 5: first data-memory address read out after `DONE`.
- `RES_COUNT`, 4: number of result bytes streamed (1–256).
- `TIMEOUT_CYCLES`, 100000: maximum RUN cycles before the run is aborted.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `CLK` input 1: the single clock.
  - `RESET` input 1: synchronous, active-high.
- Run control:
  - `GO` input 1: request a run; sampled only in IDLE.
  - `BUSY` output 1: high in every state except IDLE.
  - `ERR_TIMEOUT` output 1: sticky; set on timeout, cleared when `GO` is accepted.
- Processor side:
  - `START` output 1: to `toplevel.START`; high holds the processor in reset.
  - `DONE` input 1: from `toplevel.DONE`.
- Data-memory load port:
  - `LD_WE` output 1: write enable.
  - `LD_ADDR` output 8: write address.
  - `LD_DATA` output 8: write data.
- Data-memory read port (combinational read, same-cycle data):
  - `RD_ADDR` output 8: read address.
  - `RD_DATA` input 8: read data.
- Preload stream in:
  - `PL_VALID` input 1, `PL_READY` output 1: handshake.
  - `PL_ADDR` input 8, `PL_DATA` input 8: target address and byte.
  - `PL_LAST` input 1: marks the final preload beat.
- Result stream out:
  - `RES_VALID` output 1, `RES_READY` input 1: handshake.
  - `RES_DATA` output 8: result byte.
  - `RES_LAST` output 1: marks the final result beat.

## Operation
- States: IDLE, CLEAR, PRELOAD, LAUNCH, RUN, DRAIN.
- Reset values:
  - `START`=1.
  - `BUSY`, `ERR_TIMEOUT`, `LD_WE`, `PL_READY`, `RES_VALID`, `RES_LAST` = 0.
  - `LD_ADDR`, `LD_DATA`, `RD_ADDR`, `RES_DATA` = 0.
  - State = IDLE.
- IDLE:
  - `START`=1.
  - `GO`=1 → CLEAR next cycle, clear `ERR_TIMEOUT`, idx←0.
- CLEAR:
  - `LD_WE`=1, `LD_ADDR`=idx, `LD_DATA`=0, `START`=1.
  - Runs 256 cycles (idx 0..255); after idx=255 → PRELOAD.
- PRELOAD:
  - `PL_READY`=1, `START`=1.
  - Each cycle with `PL_VALID`=1: `LD_WE`=1, `LD_ADDR`=`PL_ADDR`, `LD_DATA`=`PL_DATA`, combinationally in that cycle.
  - Accepted beat with `PL_LAST`=1 → LAUNCH, cnt←0.
  - `PL_LAST` without `PL_VALID` is ignored.
  - A later beat to the same address overwrites the earlier one.
- LAUNCH:
  - `START`=1 for exactly `START_CYCLES` cycles, then → RUN, cnt←0.
  - `DONE` is ignored here, because the processor is held in reset.
- RUN:
  - `START`=0; cnt increments each cycle.
  - `DONE`=1 → DRAIN, idx←0.
  - If cnt reaches `TIMEOUT_CYCLES`−1 with `DONE` still low → set `ERR_TIMEOUT`, → IDLE.
  - If both conditions occur in the same cycle, `DONE` wins.
- DRAIN:
  - `START`=0.
  - `RD_ADDR`=(`RES_BASE`+idx) mod 256, 8-bit wrap.
  - `RES_VALID`=1, `RES_DATA`=`RD_DATA` (combinational), `RES_LAST`=(idx==`RES_COUNT`−1).
  - idx advances only on `RES_VALID`&`RES_READY`.
  - While stalled, `RES_DATA` and `RD_ADDR` hold.
  - Last beat accepted → IDLE.
- Outputs outside the states listed above: `LD_WE`=0, `PL_READY`=0, `RES_VALID`=0.
- `GO` outside IDLE is ignored; there is no queuing.
- `RESET` mid-operation: next cycle all outputs are at their reset values and no further writes are issued. A partially written memory is left as-is.
- Counter widths: idx 9 bits; cnt `$clog2(TIMEOUT_CYCLES+1)` bits.

## Timing
- `GO` sampled at cycle 0 → first clear write (`LD_ADDR`=0) in cycle 1; last clear write (`LD_ADDR`=255) in cycle 256.
- `PL_READY` rises in cycle 257.
- After the `PL_LAST` beat is accepted in cycle p, `START` is high for cycles p+1..p+`START_CYCLES` and falls at p+`START_CYCLES`+1.
- `DONE` sampled high in cycle d → first `RES_VALID` in cycle d+1.
- With `RES_READY` held high, the final beat is in cycle d+`RES_COUNT`; `BUSY` falls in cycle d+`RES_COUNT`+1.
- Best-case throughput: one preload beat per cycle and one result beat per cycle.

## Test plan
- **Full run:**
  - Stimulus: reset, `GO`, preload beats (0,85),(1,5),(2,85),(3,5, last). A processor stub raises `DONE` 20 cycles after `START` falls, with mem[5..8]=1,2,3,4.
  - Response: 256 zero writes, then 4 preload writes. `START` high 2 cycles after the last beat. Results 1,2,3,4 with `RES_LAST` on the 4th, then IDLE.
- **Result backpressure:**
  - Stimulus: `RES_READY` toggled 1,0,0,1,0,1,1.
  - Response: each byte is held stable while stalled; no byte is duplicated or dropped; `RD_ADDR` sequence is 5,6,7,8.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=50, `DONE` never asserted.
  - Response: `ERR_TIMEOUT`=1 and IDLE, with `START`=1, exactly 50 cycles after `START` fell. The next `GO` clears `ERR_TIMEOUT`.
- **Reset mid-CLEAR:**
  - Stimulus: `RESET` asserted while `LD_ADDR`=100.
  - Response: the following cycle has `LD_WE`=0, `START`=1, `BUSY`=0, state IDLE.
- **Address wrap:**
  - Stimulus: `RES_BASE`=254, `RES_COUNT`=4.
  - Response: `RD_ADDR` sequence 254,255,0,1.
- **Ignored inputs:**
  - Stimulus: `GO` held high throughout a run; `DONE` pulsed during LAUNCH.
  - Response: no restart occurs; RUN is still entered and DRAIN is reached only on a `DONE` sampled in RUN.
